// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the RAM port arbiter.
// Arbiter FSM state, grant encoding, default widths, counter width helper.
package ram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_FILL = 2'd2
  } grant_t;

  localparam int DEF_WIDTH          = 16;
  localparam int DEF_REGISTER_COUNT = 2048;
  localparam int DEF_AW             = $clog2(DEF_REGISTER_COUNT);

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/screen_fill_engine.sv
// screen_fill_engine: sequences one pattern word over the framebuffer.
// Ports: i_clk/i_rst, i_fill_start/i_fill_pattern, i_fill_gnt in;
// o_fill_req/o_fill_addr/o_fill_data, o_fill_busy/o_fill_done out.
module screen_fill_engine
  import ram_arb_pkg::*;
#(
  parameter int WIDTH             = DEF_WIDTH,
  parameter int AW                = DEF_AW,
  parameter int RAM_SCREEN_OFFSET = 1024,
  parameter int SCREEN_WORDS      = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fill_start,
  input  logic [WIDTH-1:0] i_fill_pattern,
  input  logic             i_fill_gnt,
  output logic             o_fill_req,
  output logic [AW-1:0]    o_fill_addr,
  output logic [WIDTH-1:0] o_fill_data,
  output logic             o_fill_busy,
  output logic             o_fill_done
);

  localparam int CW = cnt_w(SCREEN_WORDS);
  localparam logic [CW-1:0] LAST = CW'(SCREEN_WORDS - 1);

  arb_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pat;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pat   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_fill_start) begin
            r_state <= FILL;
            r_busy  <= 1'b1;
            r_pat   <= i_fill_pattern;
            r_cnt   <= '0;
          end
        end
        FILL: begin
          if (i_fill_gnt) begin
            // stop exactly on the last index, never wrap
            if (r_cnt == LAST) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_fill_req  = (r_state == FILL);
  assign o_fill_addr = AW'(RAM_SCREEN_OFFSET) + AW'(r_cnt);
  assign o_fill_data = r_pat;
  assign o_fill_busy = r_busy;
  assign o_fill_done = r_done;

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the RAM CPU port between CPU and fill engine.
// Ports: CPUclk/rst; cpu_* request side; fill_* control; ram_* RAM port.
// Build option: RAM_ARB_STARVE_GUARD_EN forces a fill grant after
// STARVE_LIMIT back-to-back CPU grants during a fill.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH             = DEF_WIDTH,
  parameter int REGISTER_COUNT    = DEF_REGISTER_COUNT,
  parameter int RAM_SCREEN_OFFSET = 1024,
  parameter int SCREEN_WORDS      = 1024,
  parameter int STARVE_LIMIT      = 4,
  localparam int AW = $clog2(REGISTER_COUNT)
) (
  input  logic             CPUclk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  input  logic             cpu_we,
  output logic             cpu_ready,
  output logic             cpu_rvalid,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic             fill_start,
  input  logic [WIDTH-1:0] fill_pattern,
  output logic             fill_busy,
  output logic             fill_done,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_we,
  input  logic [WIDTH-1:0] ram_rdata
);

`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  grant_t           w_gnt;
  logic             w_fill_req;
  logic             w_fill_ok;
  logic             w_force;
  logic [AW-1:0]    w_fill_addr;
  logic [WIDTH-1:0] w_fill_data;
  logic [SW-1:0]    r_starve;
  logic             r_rvalid;

  screen_fill_engine #(
    .WIDTH             (WIDTH),
    .AW                (AW),
    .RAM_SCREEN_OFFSET (RAM_SCREEN_OFFSET),
    .SCREEN_WORDS      (SCREEN_WORDS)
  ) u_fill (
    .i_clk          (CPUclk),
    .i_rst          (rst),
    .i_fill_start   (fill_start),
    .i_fill_pattern (fill_pattern),
    .i_fill_gnt     (w_gnt == GNT_FILL),
    .o_fill_req     (w_fill_req),
    .o_fill_addr    (w_fill_addr),
    .o_fill_data    (w_fill_data),
    .o_fill_busy    (fill_busy),
    .o_fill_done    (fill_done)
  );

  // no fill write may land during reset
  assign w_fill_ok = w_fill_req & ~rst;
  assign w_force   = GUARD && (r_starve == SW'(STARVE_LIMIT));

  always_comb begin
    w_gnt = GNT_NONE;
    if (w_fill_ok && w_force)
      w_gnt = GNT_FILL;
    else if (cpu_req)
      w_gnt = GNT_CPU;
    else if (w_fill_ok)
      w_gnt = GNT_FILL;
  end

  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = 1'b0;
    unique case (1'b1)
      (w_gnt == GNT_CPU): ram_we = cpu_we;
      (w_gnt == GNT_FILL): begin
        ram_addr  = w_fill_addr;
        ram_wdata = w_fill_data;
        ram_we    = 1'b1;
      end
      default: ;
    endcase
  end

  // consecutive CPU wins while a fill waits; saturates at the limit
  always_ff @(posedge CPUclk) begin
    if (rst || !w_fill_req || w_gnt == GNT_FILL)
      r_starve <= '0;
    else if (w_gnt == GNT_CPU && r_starve != SW'(STARVE_LIMIT))
      r_starve <= r_starve + SW'(1);
  end

  always_ff @(posedge CPUclk) begin
    if (rst)
      r_rvalid <= 1'b0;
    else
      r_rvalid <= (w_gnt == GNT_CPU) && !cpu_we;
  end

  assign cpu_ready  = (w_gnt == GNT_CPU);
  assign cpu_rvalid = r_rvalid;
  assign cpu_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter.
// Small RAM model behind the port; cycle-by-cycle expectations.
module tb_ram_port_arbiter;

  localparam int W   = 16;
  localparam int RC  = 64;
  localparam int OFF = 16;
  localparam int SWD = 8;
  localparam int SL  = 4;
  localparam int AW  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [W-1:0]  cpu_wdata;
  logic          cpu_we;
  logic          cpu_ready;
  logic          cpu_rvalid;
  logic [W-1:0]  cpu_rdata;
  logic          fill_start;
  logic [W-1:0]  fill_pattern;
  logic          fill_busy;
  logic          fill_done;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata;
  logic          ram_we;
  logic [W-1:0]  ram_rdata;

  logic [W-1:0]  mem [RC];

  int n_chk  = 0;
  int n_fail = 0;

  ram_port_arbiter #(
    .WIDTH             (W),
    .REGISTER_COUNT    (RC),
    .RAM_SCREEN_OFFSET (OFF),
    .SCREEN_WORDS      (SWD),
    .STARVE_LIMIT      (SL)
  ) dut (
    .CPUclk       (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_we       (cpu_we),
    .cpu_ready    (cpu_ready),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_rdata    (cpu_rdata),
    .fill_start   (fill_start),
    .fill_pattern (fill_pattern),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic quiet();
    cpu_req      = 1'b0;
    cpu_we       = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    fill_start   = 1'b0;
    fill_pattern = '0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    smp();
    n_chk++;
    if (fill_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy: got %b want 0", fill_busy);
    end
    n_chk++;
    if (fill_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_done: got %b want 0", fill_done);
    end
    n_chk++;
    if (cpu_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rst_rvalid: got %b want 0", cpu_rvalid);
    end
    n_chk++;
    if ({ram_we, cpu_ready} !== 2'b00) begin
      n_fail++; $display("FAIL rst_we_ready: got %b want 00", {ram_we, cpu_ready});
    end
    step();
  endtask

  task automatic test_cpu_rw();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd5; cpu_wdata = 16'hCAFE;
    smp();
    n_chk++;
    if ({cpu_ready, ram_we, ram_addr, ram_wdata} !== {2'b11, 6'd5, 16'hCAFE}) begin
      n_fail++;
      $display("FAIL cpu_wr: got rdy=%b we=%b a=%h d=%h want 1 1 05 cafe",
               cpu_ready, ram_we, ram_addr, ram_wdata);
    end
    step();
    cpu_we = 1'b0;
    smp();
    n_chk++;
    if ({cpu_ready, ram_we, cpu_rvalid} !== 3'b100) begin
      n_fail++; $display("FAIL cpu_rd: got rdy/we/rv=%b want 100", {cpu_ready, ram_we, cpu_rvalid});
    end
    step();
    cpu_req = 1'b0;
    smp();
    n_chk++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'hCAFE}) begin
      n_fail++; $display("FAIL cpu_rdata: got rv=%b d=%h want 1 cafe", cpu_rvalid, cpu_rdata);
    end
    step();
    smp();
    n_chk++;
    if (cpu_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rvalid_drop: got %b want 0", cpu_rvalid);
    end
    step();
  endtask

  task automatic test_fill();
    fill_start = 1'b1; fill_pattern = 16'hBEEF;
    smp();
    n_chk++;
    if (fill_busy !== 1'b0) begin
      n_fail++; $display("FAIL fill_c0_busy: got %b want 0", fill_busy);
    end
    step();
    for (int k = 1; k <= 10; k++) begin
      fill_start   = (k == 3);
      fill_pattern = 16'h1111;
      smp();
      if (k <= SWD) begin
        n_chk++;
        if ({ram_we, ram_addr, ram_wdata, fill_busy, fill_done} !==
            {1'b1, AW'(OFF + k - 1), 16'hBEEF, 2'b10}) begin
          n_fail++;
          $display("FAIL fill_wr c%0d: got we=%b a=%h d=%h b=%b dn=%b", k,
                   ram_we, ram_addr, ram_wdata, fill_busy, fill_done);
        end
      end else begin
        n_chk++;
        if ({fill_done, fill_busy, ram_we} !== {(k == 9), 2'b00}) begin
          n_fail++;
          $display("FAIL fill_end c%0d: got dn/b/we=%b want %b00", k,
                   {fill_done, fill_busy, ram_we}, (k == 9));
        end
      end
      step();
    end
    for (int i = 0; i < SWD; i++) begin
      n_chk++;
      if (mem[OFF + i] !== 16'hBEEF) begin
        n_fail++; $display("FAIL fill_mem %0d: got %h want beef", i, mem[OFF + i]);
      end
    end
  endtask

  task automatic test_cpu_stall();
    fill_start = 1'b1; fill_pattern = 16'h5A5A;
    step();
    fill_start = 1'b0;
    cpu_addr = 6'd5; cpu_we = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      cpu_req = (k >= 4 && k <= 6);
      smp();
      if (k >= 4 && k <= 6) begin
        n_chk++;
        if ({cpu_ready, ram_we} !== 2'b10) begin
          n_fail++; $display("FAIL stall_cpu c%0d: got rdy/we=%b want 10", k, {cpu_ready, ram_we});
        end
      end else if (k <= 11) begin
        n_chk++;
        if ({ram_we, ram_addr, ram_wdata} !==
            {1'b1, AW'(OFF + ((k <= 3) ? k - 1 : k - 4)), 16'h5A5A}) begin
          n_fail++;
          $display("FAIL stall_fill c%0d: got we=%b a=%h d=%h", k, ram_we, ram_addr, ram_wdata);
        end
      end
      n_chk++;
      if (fill_done !== (k == 12)) begin
        n_fail++; $display("FAIL stall_done c%0d: got %b want %b", k, fill_done, (k == 12));
      end
      step();
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_last_index();
    fill_start = 1'b1; fill_pattern = 16'hA5A5;
    step();
    fill_start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cpu_req = (k == 8);
      smp();
      if (k == 8) begin
        n_chk++;
        if ({cpu_ready, ram_we, fill_busy} !== 3'b101) begin
          n_fail++; $display("FAIL last_cpu: got rdy/we/b=%b want 101", {cpu_ready, ram_we, fill_busy});
        end
      end else if (k <= 9) begin
        n_chk++;
        if ({ram_we, ram_addr} !== {1'b1, AW'(OFF + ((k <= 7) ? k - 1 : 7))}) begin
          n_fail++; $display("FAIL last_wr c%0d: got we=%b a=%h", k, ram_we, ram_addr);
        end
      end
      n_chk++;
      if (fill_done !== (k == 10)) begin
        n_fail++; $display("FAIL last_done c%0d: got %b want %b", k, fill_done, (k == 10));
      end
      step();
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_starve();
    fill_start = 1'b1; fill_pattern = 16'h0F0F;
    step();
    fill_start = 1'b0;
    cpu_addr = 6'd5; cpu_we = 1'b0;
`ifdef RAM_ARB_STARVE_GUARD_EN
    cpu_req = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      smp();
      if (k <= 40 && (k % 5) == 0) begin
        n_chk++;
        if ({cpu_ready, ram_we, ram_addr, ram_wdata} !==
            {2'b01, AW'(OFF + k / 5 - 1), 16'h0F0F}) begin
          n_fail++;
          $display("FAIL starve_fill c%0d: got rdy=%b we=%b a=%h d=%h", k,
                   cpu_ready, ram_we, ram_addr, ram_wdata);
        end
      end else begin
        n_chk++;
        if ({cpu_ready, ram_we} !== 2'b10) begin
          n_fail++; $display("FAIL starve_cpu c%0d: got rdy/we=%b want 10", k, {cpu_ready, ram_we});
        end
      end
      n_chk++;
      if (fill_done !== (k == 41)) begin
        n_fail++; $display("FAIL starve_done c%0d: got %b want %b", k, fill_done, (k == 41));
      end
      step();
    end
    cpu_req = 1'b0;
`else
    cpu_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      smp();
      n_chk++;
      if ({cpu_ready, ram_we, fill_busy, fill_done} !== 4'b1010) begin
        n_fail++;
        $display("FAIL strict_cpu c%0d: got rdy/we/b/dn=%b want 1010", k,
                 {cpu_ready, ram_we, fill_busy, fill_done});
      end
      step();
    end
    cpu_req = 1'b0;
    for (int k = 21; k <= 29; k++) begin
      smp();
      if (k <= 28) begin
        n_chk++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, AW'(OFF + k - 21), 16'h0F0F}) begin
          n_fail++;
          $display("FAIL strict_fill c%0d: got we=%b a=%h d=%h", k, ram_we, ram_addr, ram_wdata);
        end
      end
      n_chk++;
      if (fill_done !== (k == 29)) begin
        n_fail++; $display("FAIL strict_done c%0d: got %b want %b", k, fill_done, (k == 29));
      end
      step();
    end
`endif
  endtask

  task automatic test_reset_mid();
    fill_start = 1'b1; fill_pattern = 16'h1234;
    step();
    fill_start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    smp();
    n_chk++;
    if (ram_we !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_we: got %b want 0", ram_we);
    end
    step();
    rst = 1'b0;
    smp();
    n_chk++;
    if ({fill_busy, fill_done} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_busy: got b/dn=%b want 00", {fill_busy, fill_done});
    end
    for (int k = 0; k < 12; k++) begin
      step();
      smp();
      n_chk++;
      if ({fill_done, ram_we} !== 2'b00) begin
        n_fail++; $display("FAIL rstmid_idle c%0d: got dn/we=%b want 00", k, {fill_done, ram_we});
      end
    end
    step();
    for (int i = 0; i < SWD; i++) begin
      n_chk++;
      if (mem[OFF + i] !== ((i < 3) ? 16'h1234 : 16'h0F0F)) begin
        n_fail++;
        $display("FAIL rstmid_mem %0d: got %h want %h", i, mem[OFF + i],
                 (i < 3) ? 16'h1234 : 16'h0F0F);
      end
    end
  endtask

  task automatic test_start_with_read();
    bit seen;
    fill_start = 1'b1; fill_pattern = 16'h7777;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd5;
    smp();
    n_chk++;
    if ({cpu_ready, ram_we} !== 2'b10) begin
      n_fail++; $display("FAIL sim_grant: got rdy/we=%b want 10", {cpu_ready, ram_we});
    end
    step();
    quiet();
    smp();
    n_chk++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'hCAFE}) begin
      n_fail++; $display("FAIL sim_rd: got rv=%b d=%h want 1 cafe", cpu_rvalid, cpu_rdata);
    end
    n_chk++;
    if ({ram_we, ram_addr, ram_wdata, fill_busy} !== {1'b1, AW'(OFF), 16'h7777, 1'b1}) begin
      n_fail++;
      $display("FAIL sim_fill0: got we=%b a=%h d=%h b=%b", ram_we, ram_addr, ram_wdata, fill_busy);
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      smp();
      seen = fill_done;
    end
    n_chk++;
    if (!seen) begin
      n_fail++; $display("FAIL sim_done: got no fill_done within 20 cycles");
    end
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_fill();
    test_cpu_stall();
    test_last_index();
    test_starve();
    test_reset_mid();
    test_start_with_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
